// File: rtl/pulse_comm_pkg.sv
// Shared definitions for the enable widen/narrow pair: FSM encodings, statistics width
// and a saturating-increment helper.
package pulse_comm_pkg;

    typedef enum logic [1:0] {
        NE_IDLE    = 2'd0,
        NE_MEASURE = 2'd1,
        NE_STUCK   = 2'd2
    } ne_state_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/narrow_enable_if.sv
// Enable-narrowing link: widened enable in, recovered pulse and width/fault strobes out.
interface narrow_enable_if #(
    parameter int CW = 5
);
    logic          src_signal_i;
    logic          dest_pulse_o;
    logic [CW-1:0] width_o;
    logic          width_valid_o;
    logic          err_short_o;
    logic          err_long_o;

    modport master (
        output src_signal_i,
        input  dest_pulse_o, width_o, width_valid_o, err_short_o, err_long_o
    );

    modport slave (
        input  src_signal_i,
        output dest_pulse_o, width_o, width_valid_o, err_short_o, err_long_o
    );
endinterface

// File: rtl/sync_bits.sv
// Multi-flop synchroniser for a single asynchronous bit, with a parameterised reset value.
module sync_bits #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= {STAGES{RST_VAL}};
        else          r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/narrow_enable.sv
// Recovers one pulse per qualified widened enable, measures its width and flags short/stuck
// enables. Optional statistics counters are built when NARROW_ENABLE_STAT_EN is defined.
module narrow_enable
    import pulse_comm_pkg::*;
#(
    parameter logic ACTIVE_LEVEL = 1'b1,
    parameter int   SYNC_STAGES  = 2,
    parameter int   MIN_WIDTH    = 3,
    parameter int   MAX_WIDTH    = 16,
    parameter int   CW           = $clog2(MAX_WIDTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
`ifdef NARROW_ENABLE_STAT_EN
    input  logic              stat_clr_i,
    output logic [STAT_W-1:0] pulse_cnt_o,
    output logic [STAT_W-1:0] err_cnt_o,
`endif
    narrow_enable_if.slave    ne
);

    logic          w_sync;
    logic          w_act;
    ne_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CW-1:0] r_width;
    logic          r_pulse, r_vld, r_short, r_long;
    logic          w_pulse_nxt, w_vld_nxt, w_short_nxt, w_long_nxt;

    sync_bits #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (~ACTIVE_LEVEL)
    ) u_sync (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_d     (ne.src_signal_i),
        .o_q     (w_sync)
    );

    assign w_act = (w_sync == ACTIVE_LEVEL);

    // Run length including the sample being evaluated this cycle.
    assign w_cnt_inc = (r_state == NE_IDLE) ? CW'(1) : r_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= NE_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            NE_IDLE, NE_MEASURE: begin
                if (!w_act)                            w_state_nxt = NE_IDLE;
                else if (w_cnt_inc == CW'(MAX_WIDTH))  w_state_nxt = NE_STUCK;
                else                                   w_state_nxt = NE_MEASURE;
            end
            NE_STUCK: if (!w_act) w_state_nxt = NE_IDLE;
            default:  w_state_nxt = NE_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        w_vld_nxt   = 1'b0;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        unique case (r_state)
            NE_IDLE, NE_MEASURE: begin
                if (w_act) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_pulse_nxt = (w_cnt_inc == CW'(MIN_WIDTH));
                    w_long_nxt  = (w_cnt_inc == CW'(MAX_WIDTH));
                end else begin
                    w_cnt_nxt = '0;
                    if (r_state == NE_MEASURE) begin
                        w_short_nxt = (r_cnt < CW'(MIN_WIDTH));
                        w_vld_nxt   = (r_cnt >= CW'(MIN_WIDTH));
                    end
                end
            end
            // Counter holds at MAX_WIDTH while stuck; no wrap.
            NE_STUCK: if (!w_act) w_cnt_nxt = '0;
            default:  w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_width <= '0;
            r_pulse <= 1'b0;
            r_vld   <= 1'b0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_vld   <= w_vld_nxt;
            r_short <= w_short_nxt;
            r_long  <= w_long_nxt;
            if (w_vld_nxt) r_width <= r_cnt;
        end
    end

    assign ne.dest_pulse_o  = r_pulse;
    assign ne.width_o       = r_width;
    assign ne.width_valid_o = r_vld;
    assign ne.err_short_o   = r_short;
    assign ne.err_long_o    = r_long;

`ifdef NARROW_ENABLE_STAT_EN
    logic [STAT_W-1:0] r_pulse_cnt, r_err_cnt;

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pulse_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (stat_clr_i) begin
            r_pulse_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_pulse)           r_pulse_cnt <= sat_inc(r_pulse_cnt);
            if (r_short || r_long) r_err_cnt   <= sat_inc(r_err_cnt);
        end
    end

    assign pulse_cnt_o = r_pulse_cnt;
    assign err_cnt_o   = r_err_cnt;
`endif

endmodule
